ov7670_frame_ctrl: RTL

Frame-level capture sequencer for the OV7670 pixel path, in the sensor's `pclk_24` domain. Arms on `start` and locks to the next frame start (`vsync` falling). Pairs `href`-qualified bytes into RGB565 pixels and generates framebuffer write strobes and addresses. Manages ping-pong framebuffer banks with a release handshake from the downstream reader, and flags malformed frames.

---
 rtl/ov7670_pkg.sv | 26 ++
 rtl/ov7670_frame_ctrl_bank_tracker.sv | 75 +++++++
 rtl/ov7670_frame_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// ----------------------------------------------------------------------------
// ov7670_pkg
// Shared types and defaults for the OV7670 frame capture path.
//   state_t   : capture sequencer states (IDLE, WAIT_VS, CAPTURE)
//   rgb565_t  : one RGB565 pixel; the first sensor byte lands in [15:8]
//   DEF_*     : default frame geometry (VGA) and framebuffer address width
// ----------------------------------------------------------------------------
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;
    localparam int DEF_ADDR_W   = 19;

endpackage

// File: rtl/ov7670_frame_ctrl_bank_tracker.sv
// ----------------------------------------------------------------------------
// ov7670_bank_tracker
// Keeps the full/free state of the framebuffer banks and the pointer to the
// bank the next frame should go into.
//   clk_i, rst_i   : pixel clock, asynchronous active-high reset
//   frame_end_i    : a captured frame just completed into end_bank_i
//   end_bank_i     : bank that was completed
//   rd_release_i   : reader has finished with rel_bank_i (one-cycle pulse)
//   rel_bank_i     : bank being released
//   capturing_i    : the sequencer is currently writing cur_bank_i
//   cur_bank_i     : bank being written
//   tgt_bank_o     : bank the next frame will be written into
//   tgt_full_o     : that bank still holds an unreleased frame
// Build option OV7670_PINGPONG_EN: two alternating banks. Without it only
// bank 0 exists, the pointer never moves and rel_bank_i is ignored.
// ----------------------------------------------------------------------------
module ov7670_bank_tracker (
    input  logic clk_i,
    input  logic rst_i,
    input  logic frame_end_i,
    input  logic end_bank_i,
    input  logic rd_release_i,
    input  logic rel_bank_i,
    input  logic capturing_i,
    input  logic cur_bank_i,
    output logic tgt_bank_o,
    output logic tgt_full_o
);

    logic [1:0] full_q, full_d;
    logic       tgt_q, tgt_d;

    // Release is applied first so that a frame end on the same bank in the
    // same cycle overrides it and the bank stays full.
    always_comb begin
        full_d = full_q;
        tgt_d  = tgt_q;
`ifdef OV7670_PINGPONG_EN
        if (rd_release_i && !(capturing_i && (rel_bank_i == cur_bank_i))) begin
            full_d[rel_bank_i] = 1'b0;
        end
        if (frame_end_i) begin
            full_d[end_bank_i] = 1'b1;
            tgt_d              = ~tgt_q;
        end
`else
        if (rd_release_i && !capturing_i) begin
            full_d[0] = 1'b0;
        end
        if (frame_end_i) begin
            full_d[0] = 1'b1;
        end
`endif
    end

`ifndef OV7670_PINGPONG_EN
    // Bank selects carry no information with a single bank.
    logic unused_bank_sel;
    assign unused_bank_sel = end_bank_i ^ rel_bank_i ^ cur_bank_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 2'b00;
            tgt_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            tgt_q  <= tgt_d;
        end
    end

    assign tgt_bank_o = tgt_q;
    assign tgt_full_o = full_q[tgt_q];

endmodule

// File: rtl/ov7670_frame_ctrl.sv
// ----------------------------------------------------------------------------
// ov7670_frame_ctrl
// Frame-level capture sequencer for the OV7670 pixel path (pclk_24 domain).
// Arms on start, locks onto the next vsync falling edge, pairs href-qualified
// bytes into RGB565 pixels and emits framebuffer writes into ping-pong banks.
//   pclk_24, rst          : pixel clock, asynchronous active-high reset
//   start, continuous     : arm request (IDLE only) / auto re-arm after a frame
//   abort                 : synchronous return to IDLE, frame discarded
//   vsync, href, d        : sensor sync and data byte
//   rd_release, rel_bank  : reader hands bank rel_bank back
//   fb_we/fb_addr/fb_data : framebuffer write port, fb_sel = bank written
//   frame_done, done_bank, frame_err : end-of-frame pulse and status
//   busy                  : sequencer not in IDLE
// Build option OV7670_PINGPONG_EN enables the second bank; without it fb_sel
// and done_bank remain 0 and a new frame waits until bank 0 is released.
// ----------------------------------------------------------------------------
module ov7670_frame_ctrl
    import ov7670_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              pclk_24,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              rd_release,
    input  logic              rel_bank,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_data,
    output logic              fb_sel,
    output logic              frame_done,
    output logic              done_bank,
    output logic              frame_err,
    output logic              busy
);

    // Counters carry one extra bit so that H_PIXELS*V_LINES == 2^ADDR_W works.
    localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W+1)'(H_PIXELS * V_LINES);
    localparam logic [ADDR_W:0] H_CNT     = (ADDR_W+1)'(H_PIXELS);
    localparam logic [ADDR_W:0] V_CNT     = (ADDR_W+1)'(V_LINES);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    logic              vsync_q, vsync_qq, href_q, href_qq;
    logic [7:0]        d_q;
    state_t            state_q;
    logic              phase_q;
    logic [7:0]        hi_byte_q;
    logic [ADDR_W:0]   addr_q, pix_cnt_q, line_cnt_q;
    logic              err_q;
    logic              pix_we_q;
    rgb565_t           pix_data_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic              fb_we_q, fb_sel_q, frame_done_q, done_bank_q, frame_err_q;
    logic [ADDR_W-1:0] fb_addr_q;
    rgb565_t           fb_data_q;

    logic vs_fall, vs_rise, href_fall, frame_end, capturing;
    logic tgt_bank, tgt_full;

    // Sensor inputs are registered once; edges are taken on the registered copies.
    always_ff @(posedge pclk_24 or posedge rst) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            href_q   <= 1'b0;
            href_qq  <= 1'b0;
            d_q      <= '0;
        end else begin
            vsync_q  <= vsync;
            vsync_qq <= vsync_q;
            href_q   <= href;
            href_qq  <= href_q;
            d_q      <= d;
        end
    end

    assign vs_fall   = vsync_qq & ~vsync_q;
    assign vs_rise   = ~vsync_qq & vsync_q;
    assign href_fall = href_qq & ~href_q;
    assign capturing = (state_q == CAPTURE);
    assign frame_end = capturing & vs_rise & ~abort;

    ov7670_bank_tracker u_banks (
        .clk_i        (pclk_24),
        .rst_i        (rst),
        .frame_end_i  (frame_end),
        .end_bank_i   (fb_sel_q),
        .rd_release_i (rd_release),
        .rel_bank_i   (rel_bank),
        .capturing_i  (capturing),
        .cur_bank_i   (fb_sel_q),
        .tgt_bank_o   (tgt_bank),
        .tgt_full_o   (tgt_full)
    );

    // Sequencer plus pixel pipeline: pixels are assembled one cycle after the
    // second byte is registered, then presented on the write port a cycle later.
    always_ff @(posedge pclk_24 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            hi_byte_q    <= '0;
            addr_q       <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            err_q        <= 1'b0;
            pix_we_q     <= 1'b0;
            pix_data_q   <= '0;
            pix_addr_q   <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_sel_q     <= 1'b0;
            frame_done_q <= 1'b0;
            done_bank_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            pix_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            fb_we_q      <= pix_we_q;
            fb_addr_q    <= pix_addr_q;
            fb_data_q    <= pix_data_q;
            if (abort) begin
                state_q <= IDLE;
                phase_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= WAIT_VS;
                        end
                    end
                    WAIT_VS: begin
                        // A frame whose target bank is still held by the reader is skipped.
                        if (vs_fall && !tgt_full) begin
                            state_q    <= CAPTURE;
                            fb_sel_q   <= tgt_bank;
                            phase_q    <= 1'b0;
                            addr_q     <= '0;
                            pix_cnt_q  <= '0;
                            line_cnt_q <= '0;
                            err_q      <= 1'b0;
                        end
                    end
                    CAPTURE: begin
                        if (vs_rise) begin
                            frame_done_q <= 1'b1;
                            done_bank_q  <= fb_sel_q;
                            frame_err_q  <= err_q | (line_cnt_q != V_CNT);
                            phase_q      <= 1'b0;
                            state_q      <= continuous ? WAIT_VS : IDLE;
                        end else begin
                            if (href_q) begin
                                phase_q <= ~phase_q;
                                if (!phase_q) begin
                                    hi_byte_q <= d_q;
                                end else begin
                                    pix_cnt_q <= pix_cnt_q + CNT_ONE;
                                    if (addr_q < FRAME_PIX) begin
                                        pix_we_q   <= 1'b1;
                                        pix_data_q <= {hi_byte_q, d_q};
                                        pix_addr_q <= addr_q[ADDR_W-1:0];
                                        addr_q     <= addr_q + CNT_ONE;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                            end else begin
                                phase_q <= 1'b0;
                            end
                            if (href_fall) begin
                                pix_cnt_q  <= '0;
                                line_cnt_q <= line_cnt_q + CNT_ONE;
                                if (pix_cnt_q != H_CNT) begin
                                    err_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_sel     = fb_sel_q;
    assign frame_done = frame_done_q;
    assign done_bank  = done_bank_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
